// File: rtl/msg_loader_if.sv
// Handshake and read-port bundle between a character source, the message loader and the scroller.
interface msg_loader_if #(
    parameter int MAX_LEN    = 32,
    parameter int CHAR_WIDTH = 8
);
    logic [CHAR_WIDTH-1:0]          in_char;
    logic                           in_valid;
    logic                           in_ready;
    logic [$clog2(MAX_LEN)-1:0]     rd_index;
    logic [CHAR_WIDTH-1:0]          rd_char;
    logic [$clog2(MAX_LEN+1)-1:0]   msg_len;
    logic                           msg_update;
    logic                           overflow;
    logic                           busy;

    modport master (
        output in_char, in_valid, rd_index,
        input  in_ready, rd_char, msg_len, msg_update, overflow, busy
    );

    modport slave (
        input  in_char, in_valid, rd_index,
        output in_ready, rd_char, msg_len, msg_update, overflow, busy
    );
endinterface

// File: rtl/msg_loader.sv
// Double-buffered message loader: assembles a character line into the shadow bank
// and swaps banks on a terminator so the scroller only ever sees complete messages.
module msg_loader #(
    parameter int                   MAX_LEN    = 32,
    parameter int                   CHAR_WIDTH = 8,
    parameter logic [CHAR_WIDTH-1:0] TERM_CHAR = 8'h0D
) (
    input  logic          clk,
    input  logic          rst_n,
    msg_loader_if.slave   bus
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int PW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, FILL, DROP, COMMIT} state_t;
    typedef enum logic [1:0] {C_PRINT, C_TERM, C_BS, C_ESC} cls_t;

    function automatic cls_t classify(input logic [CHAR_WIDTH-1:0] ch);
        if (ch == TERM_CHAR || ch == CHAR_WIDTH'(8'h0A)) begin
            return C_TERM;
        end else if (ch == CHAR_WIDTH'(8'h08)) begin
            return C_BS;
        end else if (ch == CHAR_WIDTH'(8'h1B)) begin
            return C_ESC;
        end else begin
            return C_PRINT;
        end
    endfunction

    state_t                 state_r, state_s;
    logic [PW-1:0]          wr_ptr_r, wr_ptr_s;
    logic                   overflow_r, overflow_s;
    logic                   active_bank_r;
    logic [PW-1:0]          msg_len_r;
    logic                   msg_update_r;
    logic                   in_ready_r;
    logic                   busy_r;
    logic                   wr_en_s;
    logic                   commit_s;
    logic                   accept_s;
    cls_t                   cls_s;
    logic [CHAR_WIDTH-1:0]  bank0_r [MAX_LEN];
    logic [CHAR_WIDTH-1:0]  bank1_r [MAX_LEN];
    logic [CHAR_WIDTH-1:0]  rd_char_s;

    assign accept_s = bus.in_valid && in_ready_r;
    assign cls_s    = classify(bus.in_char);

    // Next-state, write-pointer and overflow decode for the line-assembly FSM.
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        overflow_s = overflow_r;
        wr_en_s    = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && cls_s == C_PRINT) begin
                    wr_en_s    = 1'b1;
                    wr_ptr_s   = PW'(1);
                    overflow_s = 1'b0;
                    state_s    = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    case (cls_s)
                        C_PRINT: begin
                            if (wr_ptr_r < PW'(MAX_LEN)) begin
                                wr_en_s  = 1'b1;
                                wr_ptr_s = wr_ptr_r + PW'(1);
                            end else begin
                                overflow_s = 1'b1;
                                state_s    = DROP;
                            end
                        end
                        C_BS: begin
                            if (wr_ptr_r != PW'(0)) begin
                                wr_ptr_s = wr_ptr_r - PW'(1);
                            end else begin
                                wr_ptr_s = PW'(0);
                            end
                        end
                        C_ESC: begin
                            wr_ptr_s   = PW'(0);
                            overflow_s = 1'b0;
                            state_s    = IDLE;
                        end
                        C_TERM: begin
                            if (wr_ptr_r != PW'(0)) begin
                                state_s = COMMIT;
                            end else begin
                                state_s = IDLE;
                            end
                        end
                        default: state_s = FILL;
                    endcase
                end else begin
                    state_s = FILL;
                end
            end
            DROP: begin
                if (accept_s) begin
                    case (cls_s)
                        C_BS: begin
                            wr_ptr_s = wr_ptr_r - PW'(1);
                            state_s  = FILL;
                        end
                        C_ESC: begin
                            wr_ptr_s   = PW'(0);
                            overflow_s = 1'b0;
                            state_s    = IDLE;
                        end
                        C_TERM:  state_s = COMMIT;
                        default: state_s = DROP;
                    endcase
                end else begin
                    state_s = DROP;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                wr_ptr_s = PW'(0);
                state_s  = IDLE;
            end
            default: begin
                wr_ptr_s = PW'(0);
                state_s  = IDLE;
            end
        endcase
    end

    // FSM state plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wr_ptr_r      <= PW'(0);
            overflow_r    <= 1'b0;
            active_bank_r <= 1'b0;
            msg_len_r     <= PW'(0);
            msg_update_r  <= 1'b0;
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_ptr_r      <= wr_ptr_s;
            overflow_r    <= overflow_s;
            active_bank_r <= active_bank_r ^ commit_s;
            msg_len_r     <= commit_s ? wr_ptr_r : msg_len_r;
            msg_update_r  <= commit_s;
            in_ready_r    <= (state_s != COMMIT);
            busy_r        <= (state_s == FILL) || (state_s == DROP);
        end
    end

    // Shadow-bank character write; buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            if (active_bank_r) begin
                bank0_r[wr_ptr_r[IW-1:0]] <= bus.in_char;
            end else begin
                bank1_r[wr_ptr_r[IW-1:0]] <= bus.in_char;
            end
        end
    end

    // Scroller read port: indices past the committed length read as space.
    always_comb begin
        rd_char_s = CHAR_WIDTH'(8'h20);
        if (PW'(bus.rd_index) < msg_len_r) begin
            if (active_bank_r) begin
                rd_char_s = bank1_r[bus.rd_index];
            end else begin
                rd_char_s = bank0_r[bus.rd_index];
            end
        end else begin
            rd_char_s = CHAR_WIDTH'(8'h20);
        end
    end

    assign bus.rd_char    = rd_char_s;
    assign bus.in_ready   = in_ready_r;
    assign bus.msg_len    = msg_len_r;
    assign bus.msg_update = msg_update_r;
    assign bus.overflow   = overflow_r;
    assign bus.busy       = busy_r;
endmodule
